// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the program BRAM address, tracks the one in-flight read and
// buffers returned words in a 2-entry FIFO presented to decode via valid/ready.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              IMEM_AW  = 12,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_instr
);

    logic [XLEN-1:0]          pc_q, pc_d;
    logic [XLEN-1:0]          infl_pc_q, infl_pc_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               count_q, count_d;
    logic [1:0][XLEN-1:0]     fifo_pc_q, fifo_pc_d;
    logic [1:0][XLEN-1:0]     fifo_instr_q, fifo_instr_d;

    logic                     pop;
    logic                     push;
    logic                     issue;
    logic [2:0]               occupancy;
    logic [1:0]               wr_idx;
    logic [XLEN-1:0]          redir_pc;
    logic                     unused_bits;

    assign unused_bits = ^{redirect_pc[1:0], wr_idx[1]};

    assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_addr = redirect_valid ? redirect_pc[IMEM_AW+1:2] : pc_q[IMEM_AW+1:2];

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = fifo_pc_q[0];
    assign out_instr = fifo_instr_q[0];

    assign pop  = out_valid & out_ready;
    // A redirect discards the word returning from the stale in-flight read.
    assign push = inflight_q & ~redirect_valid;

    // Slots that will be occupied once this cycle's pop and the in-flight word settle;
    // issuing only when this is <= 1 keeps the 2-entry FIFO from overflowing.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = fetch_en & (occupancy <= 3'd1);
    assign wr_idx    = count_q - {1'b0, pop};

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred; combinational logic uses blocking '=' throughout.
    always_comb begin
        pc_d         = pc_q;
        infl_pc_d    = infl_pc_q;
        inflight_d   = inflight_q;
        count_d      = count_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;

        if (redirect_valid) begin
            pc_d       = redir_pc + XLEN'(4);
            infl_pc_d  = redir_pc;
            inflight_d = 1'b1;
            count_d    = 2'd0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_d      = pc_q + XLEN'(4);
                infl_pc_d = pc_q;
            end

            if (pop) begin
                fifo_pc_d[0]    = fifo_pc_q[1];
                fifo_instr_d[0] = fifo_instr_q[1];
            end

            if (push) begin
                fifo_pc_d[wr_idx[0]]    = infl_pc_q;
                fifo_instr_d[wr_idx[0]] = imem_dout;
            end

            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: the two FIFO entries are reset along with the control state so that the
    // outputs read as zero straight out of reset; state flops use non-blocking '<='.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q         <= RESET_PC;
            infl_pc_q    <= '0;
            inflight_q   <= 1'b0;
            count_q      <= 2'd0;
            fifo_pc_q    <= '0;
            fifo_instr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            infl_pc_q    <= infl_pc_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the model is the ideal in-order PC stream
// (restart point + 4*k) with a flush on redirect or reset; a monitor checks every handshake.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    instr_fetch_unit dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    // Program BRAM: mem[i] = 0x1000_0000 + i, one-cycle synchronous read, no enable.
    always @(posedge clk) imem_dout <= 32'h1000_0000 + {20'd0, imem_addr};

    int checks = 0;
    int passed = 0;
    int pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: the expected delivered stream, kept topped up ahead of the DUT.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_pc;

    function automatic exp_t model_word(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h1000_0000 + ((pc >> 2) % 4096);
        return e;
    endfunction

    task automatic model_restart(input logic [31:0] target);
        exp_q.delete();
        model_pc = target & ~32'd3;
    endtask

    task automatic model_fill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(model_word(model_pc));
            model_pc += 32'd4;
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge, when inputs are settled.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (n_rst && out_valid && out_ready) begin
                exp_t e;
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got pc %h with no expected entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", out_pc, e.pc);
                    check("sb_instr", out_instr, e.instr);
                end
            end
        end
    end

    // One cycle of stimulus: drive at the falling edge, update the model after the monitor.
    task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #2;
        if (rv) model_restart(rpc);
        model_fill();
    endtask

    task automatic release_reset();
        @(negedge clk);
        n_rst          = 1'b1;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        #2;
        model_fill();
    endtask

    int p0;

    initial begin
        n_rst          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_restart(32'd0);
        repeat (3) @(negedge clk);
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);

        // 1: first word appears after the 2nd rising edge, then one per cycle.
        release_reset();
        check("lat_before_edge1", {31'd0, out_valid}, 32'd0);
        step(1, 1, 0, 0);
        check("lat_after_edge1", {31'd0, out_valid}, 32'd0);
        step(1, 1, 0, 0);
        check("lat_after_edge2", {31'd0, out_valid}, 32'd1);
        check("first_pc", out_pc, 32'd0);
        step(1, 1, 0, 0);
        check("second_pc", out_pc, 32'd4);

        // 2: stall with pc 8 at the head; address and head hold, then 8,C,10 resume.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            check("stall_pc", out_pc, 32'd8);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_addr", {20'd0, imem_addr}, 32'h4);
        end
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            check("nobubble_valid", {31'd0, out_valid}, 32'd1);
        end

        // 3: redirect to 0x41 -> one bubble, then 0x40, 0x44.
        step(1, 1, 1, 32'h41);
        step(1, 1, 0, 0);
        check("redir_bubble", {31'd0, out_valid}, 32'd0);
        step(1, 1, 0, 0);
        check("redir_target_pc", out_pc, 32'h40);
        check("redir_target_instr", out_instr, 32'h1000_0010);
        step(1, 1, 0, 0);
        check("redir_next_pc", out_pc, 32'h44);

        // 4: redirect coinciding with a pop; the scoreboard keeps the popped word.
        step(1, 1, 1, 32'h200);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("redir_pop_target", out_pc, 32'h200);

        // 5: word-address wrap at the top of program memory.
        step(1, 1, 1, 32'h3FFC);
        check("wrap_addr_redir", {20'd0, imem_addr}, 32'hFFF);
        step(1, 1, 0, 0);
        check("wrap_addr_next", {20'd0, imem_addr}, 32'h0);
        step(1, 1, 0, 0);
        check("wrap_pc", out_pc, 32'h3FFC);
        check("wrap_instr", out_instr, 32'h1000_0FFF);
        step(1, 1, 0, 0);
        check("wrap_pc2", out_pc, 32'h4000);
        check("wrap_instr2", out_instr, 32'h1000_0000);

        // 6a: fetch disabled mid-stream: at most 2 more outputs, then idle; re-enable resumes.
        step(1, 1, 0, 0);
        p0 = pops;
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        check("fe_off_le2", {31'd0, (pops - p0) <= 2}, 32'd1);
        check("fe_off_idle", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);

        // 6b: async reset pulse mid-stream clears the outputs at once, restart at pc 0.
        @(negedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("rst_pulse_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pulse_pc", out_pc, 32'd0);
        check("rst_pulse_instr", out_instr, 32'd0);
        model_restart(32'd0);
        release_reset();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("rst_restart_pc", out_pc, 32'd0);

        // Randomized traffic: ready, fetch enable and redirects.
        p0 = pops;
        for (int i = 0; i < 2000; i++) begin
            bit          fe;
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            fe  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom();
            step(fe, rdy, rv, rpc);
        end
        check("random_progress", {31'd0, (pops - p0) >= 500}, 32'd1);

        step(0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
